jtcop_obj_dma: RTL and testbench

Object DMA engine for the main board's object (MIX) path. It consumes the `obj_copy` strobe and `mixpsel` page select produced by the main CPU block. It copies one page of object RAM into the inactive bank of a double-buffered object table. After the copy it flips the active bank at the next vertical blank start, so the object renderer always scans a complete, stable table.

---
 rtl/jtcop_pkg.sv | 13 +
 rtl/jtcop_obj_dma.sv | 109 ++++++++++
 tb/tb_jtcop_obj_dma.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_pkg.sv
// Shared definitions for the object path: page geometry and the object DMA state encoding.
package jtcop_pkg;

    localparam int OBJ_AW = 10;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_COPY  = 2'd1,
        DMA_DRAIN = 2'd2,
        DMA_ARMED = 2'd3
    } dma_state_t;

endpackage

// File: rtl/jtcop_obj_dma.sv
// Object DMA: copies one object RAM page into the hidden half of the double-buffered
// object table, then swaps banks at the next vertical blank start.
module jtcop_obj_dma
    import jtcop_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          obj_copy,
    input  logic          mixpsel,
    output logic [AW:0]   src_addr,
    input  logic [DW-1:0] src_data,
    output logic [AW:0]   dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          dst_we,
    output logic          bank,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    dma_state_t    state_q;
    logic          obj_copy_l_q;
    logic          lvbl_l_q;
    logic          page_q;
    logic          bank_q;
    logic          busy_q;
    logic [AW-1:0] idx_q;
    logic          valid_q;
    logic [AW-1:0] idx_p_q;
    logic          dst_bank_q;

    logic copy_edge;
    logic lvbl_fall;
    logic issue;

    assign copy_edge = obj_copy & ~obj_copy_l_q;
    assign lvbl_fall = lvbl_l_q & ~LVBL;
    assign issue     = (state_q == DMA_COPY) && cen;

    // The write-side bank bit rides in the pipeline so dst_addr is all-zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DMA_IDLE;
            obj_copy_l_q <= 1'b1;
            lvbl_l_q     <= 1'b1;
            page_q       <= 1'b0;
            bank_q       <= 1'b0;
            busy_q       <= 1'b0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            idx_p_q      <= '0;
            dst_bank_q   <= 1'b0;
        end else begin
            obj_copy_l_q <= obj_copy;
            lvbl_l_q     <= LVBL;
            valid_q      <= issue;
            if (issue) begin
                idx_q      <= idx_q + 1'b1;
                idx_p_q    <= idx_q;
                dst_bank_q <= ~bank_q;
            end
            case (state_q)
                DMA_IDLE: begin
                    if (copy_edge) begin
                        page_q  <= mixpsel;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DMA_COPY;
                    end
                end
                DMA_COPY: begin
                    if (issue && idx_q == LAST_IDX) begin
                        state_q <= DMA_DRAIN;
                    end
                end
                DMA_DRAIN: begin
                    busy_q  <= 1'b0;
                    state_q <= DMA_ARMED;
                end
                DMA_ARMED: begin
                    // A fresh request beats the pending swap and refills the same hidden bank.
                    if (copy_edge) begin
                        page_q  <= mixpsel;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DMA_COPY;
                    end else if (lvbl_fall) begin
                        bank_q  <= ~bank_q;
                        state_q <= DMA_IDLE;
                    end
                end
                default: state_q <= DMA_IDLE;
            endcase
        end
    end

    assign src_addr = {page_q, idx_q};
    assign dst_addr = {dst_bank_q, idx_p_q};
    assign dst_data = valid_q ? src_data : '0;
    assign dst_we   = valid_q;
    assign bank     = bank_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Randomised bench for jtcop_obj_dma: a cycle-level behavioural model of the copy/flip
// rules is compared against the DUT every cycle, with literal checks pinning key points.
module tb_jtcop_obj_dma;
    import jtcop_pkg::*;

    localparam int AW    = OBJ_AW;
    localparam int DW    = 16;
    localparam int WORDS = 1 << AW;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          cen      = 1'b0;
    logic          LVBL     = 1'b1;
    logic          obj_copy = 1'b1;
    logic          mixpsel  = 1'b0;
    logic [AW:0]   src_addr;
    logic [DW-1:0] src_data = '0;
    logic [AW:0]   dst_addr;
    logic [DW-1:0] dst_data;
    logic          dst_we;
    logic          bank;
    logic          busy;

    int errors = 0;
    int checks = 0;

    jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .LVBL     (LVBL),
        .obj_copy (obj_copy),
        .mixpsel  (mixpsel),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we),
        .bank     (bank),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] srcMem [2*WORDS];
    logic [DW-1:0] dbuf   [2*WORDS];

    always @(posedge clk) src_data <= srcMem[src_addr];

    // cen pattern: 0 = always on, 1 = one cycle in three, 2 = random
    int cenMode  = 0;
    int cenPhase = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (cenMode)
            0:       cen = 1'b1;
            1: begin
                cen      = (cenPhase == 0);
                cenPhase = (cenPhase + 1) % 3;
            end
            default: cen = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a copy is a count of reads issued; each read becomes a write one
    // cycle later; once all WORDS are read one drain cycle follows; then a swap is pending.
    bit mValid = 0;
    bit mActive, mArmed, mBank, mPage;
    bit mWe, mWeBank, mWePage;
    int mReads, mWeIdx;
    bit prevCopy, prevLvbl;

    always @(posedge clk) begin
        if (rst) begin
            mValid   = 1;
            mActive  = 0;
            mArmed   = 0;
            mBank    = 0;
            mPage    = 0;
            mReads   = 0;
            mWe      = 0;
            prevCopy = 1;
            prevLvbl = 1;
        end else if (mValid) begin
            mWe = 0;
            if (mActive) begin
                if (mReads < WORDS) begin
                    if (cen) begin
                        mWe     = 1;
                        mWeIdx  = mReads;
                        mWeBank = !mBank;
                        mWePage = mPage;
                        mReads++;
                    end
                end else begin
                    mActive = 0;
                    mArmed  = 1;
                end
            end else if (obj_copy && !prevCopy) begin
                mActive = 1;
                mArmed  = 0;
                mReads  = 0;
                mPage   = mixpsel;
            end else if (mArmed && prevLvbl && !LVBL) begin
                mBank  = !mBank;
                mArmed = 0;
            end
            prevCopy = obj_copy;
            prevLvbl = LVBL;
        end
    end

    int writeCount = 0;
    int busyCount  = 0;

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("busy", {31'd0, busy}, {31'd0, mActive});
            checkOutput("bank", {31'd0, bank}, {31'd0, mBank});
            checkOutput("dst_we", {31'd0, dst_we}, {31'd0, mWe});
            if (mWe) begin
                logic [AW-1:0] wi;
                wi = mWeIdx[AW-1:0];
                checkOutput("dst_addr", 32'(dst_addr), 32'({mWeBank, wi}));
                checkOutput("dst_data", 32'(dst_data), 32'(srcMem[{mWePage, wi}]));
            end
            if (mActive && mReads < WORDS && cen) begin
                logic [AW-1:0] ri;
                ri = mReads[AW-1:0];
                checkOutput("src_addr", 32'(src_addr), 32'({mPage, ri}));
            end
        end
        if (dst_we === 1'b1) begin
            dbuf[dst_addr] = dst_data;
            writeCount++;
        end
        if (busy === 1'b1) busyCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit copy, input bit psel, input bit lvbl);
        obj_copy = copy;
        mixpsel  = psel;
        LVBL     = lvbl;
        tick();
    endtask

    task automatic pulseCopy(input bit psel);
        applyStimulus(1'b1, psel, LVBL);
        obj_copy = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL waitIdleTimeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic waitWrites(input int target, input int budget);
        int n = 0;
        while (writeCount < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL waitWritesTimeout: writes %0d, required %0d", writeCount, target);
        end
    endtask

    task automatic checkRegion(input string name, input bit region, input bit page);
        int bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (dbuf[region*WORDS + i] !== srcMem[page*WORDS + i]) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    task automatic vblank();
        applyStimulus(1'b0, mixpsel, 1'b0);
        applyStimulus(1'b0, mixpsel, 1'b0);
        applyStimulus(1'b0, mixpsel, 1'b1);
    endtask

    initial begin
        logic [AW:0] probe;
        for (int i = 0; i < WORDS; i++) begin
            srcMem[i]         = 16'($urandom);
            srcMem[WORDS + i] = 16'(i) ^ 16'h5A5A;
        end
        for (int i = 0; i < 2*WORDS; i++) dbuf[i] = '0;

        $display("[TB] reset with obj_copy held high");
        repeat (3) tick();
        checkOutput("rstBusy", {31'd0, busy}, 0);
        checkOutput("rstBank", {31'd0, bank}, 0);
        checkOutput("rstDstWe", {31'd0, dst_we}, 0);
        checkOutput("rstSrcAddr", 32'(src_addr), 0);
        checkOutput("rstDstAddr", 32'(dst_addr), 0);
        checkOutput("rstDstData", 32'(dst_data), 0);
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("heldCopyNoStart", {31'd0, busy}, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] single copy, page 1, cen always on");
        cenMode    = 0;
        writeCount = 0;
        busyCount  = 0;
        pulseCopy(1'b1);
        waitIdle(3000);
        checkOutput("t1Writes", writeCount, 1024);
        checkOutput("t1BusyCycles", busyCount, 1025);
        checkRegion("t1Contents", 1'b1, 1'b1);
        probe = {1'b1, 10'd7};
        checkOutput("t1Word7", 32'(dbuf[probe]), 32'h5A5D);
        LVBL = 1'b0;
        @(negedge clk);
        checkOutput("t1BankBeforeFlip", {31'd0, bank}, 0);
        @(negedge clk);
        checkOutput("t1BankAfterFlip", {31'd0, bank}, 1);
        tick();
        LVBL = 1'b1;
        tick();

        $display("[TB] throttled copy, page 0");
        cenMode    = 1;
        writeCount = 0;
        pulseCopy(1'b0);
        waitIdle(6000);
        checkOutput("t2Writes", writeCount, 1024);
        checkRegion("t2Contents", 1'b0, 1'b0);
        vblank();
        checkOutput("t2Bank", {31'd0, bank}, 0);

        $display("[TB] retrigger during copy");
        cenMode    = 2;
        writeCount = 0;
        pulseCopy(1'b1);
        waitWrites(500, 3000);
        pulseCopy(1'b0);
        waitIdle(5000);
        checkOutput("t3Writes", writeCount, 1024);
        checkRegion("t3Contents", 1'b1, 1'b1);
        vblank();
        checkOutput("t3BankFlip", {31'd0, bank}, 1);
        vblank();
        checkOutput("t3NoSecondFlip", {31'd0, bank}, 1);

        $display("[TB] retrigger while armed");
        writeCount = 0;
        pulseCopy(1'b1);
        waitIdle(5000);
        repeat (4) tick();
        pulseCopy(1'b0);
        waitIdle(5000);
        checkOutput("t4Writes", writeCount, 2048);
        checkRegion("t4Contents", 1'b0, 1'b0);
        vblank();
        checkOutput("t4BankFlip", {31'd0, bank}, 0);
        vblank();
        checkOutput("t4NoSecondFlip", {31'd0, bank}, 0);

        $display("[TB] copy and vblank in the same cycle");
        cenMode    = 0;
        writeCount = 0;
        pulseCopy(1'b0);
        waitIdle(3000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        obj_copy = 1'b0;
        checkOutput("t5BusyRestart", {31'd0, busy}, 1);
        repeat (3) tick();
        checkOutput("t5NoFlip", {31'd0, bank}, 0);
        waitIdle(3000);
        checkRegion("t5Contents", 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        vblank();
        checkOutput("t5BankFlip", {31'd0, bank}, 1);

        $display("[TB] reset during copy");
        writeCount = 0;
        pulseCopy(1'b0);
        waitWrites(300, 3000);
        rst      = 1'b1;
        obj_copy = 1'b1;
        tick();
        checkOutput("t6Busy", {31'd0, busy}, 0);
        checkOutput("t6DstWe", {31'd0, dst_we}, 0);
        checkOutput("t6Bank", {31'd0, bank}, 0);
        rst = 1'b0;
        repeat (10) tick();
        checkOutput("t6HeldCopyNoStart", {31'd0, busy}, 0);
        obj_copy = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
